// File: rtl/tile_stream_ctrl.sv
// Tile stream sequencer: fills an external 2-D tile BRAM from a byte stream, then drains it as a
// byte stream with last-flag. Define TRANSPOSE_EN to drain y-outer/x-inner (transposed tile).
module tile_stream_ctrl #(
  parameter int TILE_X = 3,
  parameter int TILE_Y = 3,
  parameter int DW     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  input  logic          m_ready,
  output logic          ram_wr_en,
  output logic [5:0]    ram_addr_in,
  output logic [DW-1:0] ram_data_in,
  output logic          ram_rd_en,
  output logic [5:0]    ram_addr_out,
  input  logic [DW-1:0] ram_data_out,
  output logic          tile_done
);

  localparam logic [2:0] XMAX = 3'(TILE_X - 1);
  localparam logic [2:0] YMAX = 3'(TILE_Y - 1);

  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [2:0] wx_q, wx_d, wy_q, wy_d;
  logic [2:0] rx_q, rx_d, ry_q, ry_d;
  logic       pend_q, pend_d;
  logic       rd_done_q, rd_done_d;
  logic       last_q, last_d;
  logic       issue;
  logic       rd_final;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      wx_q      <= '0;
      wy_q      <= '0;
      rx_q      <= '0;
      ry_q      <= '0;
      pend_q    <= 1'b0;
      rd_done_q <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wx_q      <= wx_d;
      wy_q      <= wy_d;
      rx_q      <= rx_d;
      ry_q      <= ry_d;
      pend_q    <= pend_d;
      rd_done_q <= rd_done_d;
      last_q    <= last_d;
    end
  end

  // The final element is (TILE_X-1, TILE_Y-1) in either read order.
  assign rd_final = (rx_q == XMAX) && (ry_q == YMAX);

  always_comb begin
    state_d   = state_q;
    wx_d      = wx_q;
    wy_d      = wy_q;
    rx_d      = rx_q;
    ry_d      = ry_q;
    pend_d    = pend_q;
    rd_done_d = rd_done_q;
    last_d    = last_q;
    issue     = 1'b0;
    s_ready   = 1'b0;
    ram_wr_en = 1'b0;
    ram_rd_en = 1'b0;
    tile_done = 1'b0;

    case (state_q)
      FILL: begin
        s_ready   = 1'b1;
        ram_wr_en = s_valid;
        if (s_valid) begin
          if (wy_q == YMAX) begin
            wy_d = '0;
            if (wx_q == XMAX) begin
              wx_d    = '0;
              state_d = DRAIN;
            end else begin
              wx_d = wx_q + 3'd1;
            end
          end else begin
            wy_d = wy_q + 3'd1;
          end
        end
      end

      DRAIN: begin
        // A read may only be launched when the single output slot is empty or being emptied.
        issue     = !rd_done_q && (!pend_q || m_ready);
        ram_rd_en = issue;
        pend_d    = issue | (pend_q & ~m_ready);

        if (issue) begin
          last_d = rd_final;
          if (rd_final) begin
            rx_d      = '0;
            ry_d      = '0;
            rd_done_d = 1'b1;
          end else begin
`ifdef TRANSPOSE_EN
            if (rx_q == XMAX) begin
              rx_d = '0;
              ry_d = ry_q + 3'd1;
            end else begin
              rx_d = rx_q + 3'd1;
            end
`else
            if (ry_q == YMAX) begin
              ry_d = '0;
              rx_d = rx_q + 3'd1;
            end else begin
              ry_d = ry_q + 3'd1;
            end
`endif
          end
        end

        if (pend_q && last_q && m_ready) begin
          tile_done = 1'b1;
          state_d   = FILL;
          rx_d      = '0;
          ry_d      = '0;
          rd_done_d = 1'b0;
          last_d    = 1'b0;
        end
      end

      default: state_d = FILL;
    endcase
  end

  assign m_valid      = pend_q;
  assign m_last       = pend_q & last_q;
  assign m_data       = ram_data_out;
  assign ram_addr_in  = {wx_q, wy_q};
  assign ram_data_in  = s_data;
  assign ram_addr_out = {rx_q, ry_q};

endmodule

// File: tb/tb_tile_stream_ctrl.sv
// Directed bench for tile_stream_ctrl (3x3 tile) with a behavioural BRAM model.
module tb_tile_stream_ctrl;

  logic       clk;
  logic       rst;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_ready;
  logic       ram_wr_en;
  logic [5:0] ram_addr_in;
  logic [7:0] ram_data_in;
  logic       ram_rd_en;
  logic [5:0] ram_addr_out;
  logic [7:0] ram_data_out;
  logic       tile_done;

  int n_chk;
  int n_err;

  tile_stream_ctrl #(.TILE_X(3), .TILE_Y(3), .DW(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_last       (m_last),
    .m_ready      (m_ready),
    .ram_wr_en    (ram_wr_en),
    .ram_addr_in  (ram_addr_in),
    .ram_data_in  (ram_data_in),
    .ram_rd_en    (ram_rd_en),
    .ram_addr_out (ram_addr_out),
    .ram_data_out (ram_data_out),
    .tile_done    (tile_done)
  );

  // BRAM: synchronous write, registered read that holds when rd_en=0
  logic [7:0] mem [0:63];
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_addr_in] <= ram_data_in;
    if (ram_rd_en) ram_data_out <= mem[ram_addr_out];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       wr;
    logic [5:0] a;
  } fill_vec_t;

  fill_vec_t  gap_tab [14];
  logic [5:0] wr_addr [9];
  logic [5:0] exp_raddr [9];
  int         exp_idx [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_contig(input logic [7:0] base);
    for (int i = 0; i < 9; i++) begin
      s_valid = 1'b1;
      s_data  = base + 8'(i);
      m_ready = 1'b0;
      #4;
      chk("fill_s_ready", s_ready, 1);
      chk("fill_wr_en", ram_wr_en, 1);
      chk("fill_addr", ram_addr_in, wr_addr[i]);
      chk("fill_data", ram_data_in, base + 8'(i));
      chk("fill_rd_en", ram_rd_en, 0);
      next_cycle();
    end
    s_valid = 1'b0;
    s_data  = 8'h00;
  endtask

  task automatic drain(input int nbytes, input logic [15:0] pat, input logic [7:0] base,
                       input int iss0);
    int got;
    int iss;
    int cyc;
    logic stalled;
    logic [7:0] held;
    got = 0;
    iss = iss0;
    cyc = 0;
    stalled = 1'b0;
    held = 8'h00;
    while (got < nbytes && cyc < 64) begin
      s_valid = 1'b0;
      m_ready = pat[cyc % 16];
      #4;
      chk("drain_s_ready", s_ready, 0);
      chk("drain_wr_en", ram_wr_en, 0);
      if (stalled) chk("stall_data", m_data, held);
      if (ram_rd_en) begin
        chk("rd_slot_free", 32'(!m_valid || m_ready), 1);
        if (iss < 9) chk("rd_addr", ram_addr_out, exp_raddr[iss]);
        else chk("rd_count", iss, 8);
        iss++;
      end
      if (m_valid && m_ready) begin
        chk("m_data", m_data, base + 8'(exp_idx[got]));
        chk("m_last", m_last, 32'(got == 8));
        chk("tile_done", tile_done, 32'(got == 8));
        got++;
      end else begin
        chk("tile_done_idle", tile_done, 0);
      end
      stalled = m_valid && !m_ready;
      held = m_data;
      next_cycle();
      cyc++;
    end
    if (got < nbytes) chk("drain_timeout", got, nbytes);
    m_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    wr_addr = '{6'h00, 6'h01, 6'h02, 6'h08, 6'h09, 6'h0A, 6'h10, 6'h11, 6'h12};
`ifdef TRANSPOSE_EN
    exp_raddr = '{6'h00, 6'h08, 6'h10, 6'h01, 6'h09, 6'h11, 6'h02, 6'h0A, 6'h12};
    exp_idx   = '{0, 3, 6, 1, 4, 7, 2, 5, 8};
`else
    exp_raddr = '{6'h00, 6'h01, 6'h02, 6'h08, 6'h09, 6'h0A, 6'h10, 6'h11, 6'h12};
    exp_idx   = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
`endif
    gap_tab[0]  = '{1'b1, 8'h10, 1'b1, 6'h00};
    gap_tab[1]  = '{1'b0, 8'h55, 1'b0, 6'h01};
    gap_tab[2]  = '{1'b0, 8'h55, 1'b0, 6'h01};
    gap_tab[3]  = '{1'b1, 8'h11, 1'b1, 6'h01};
    gap_tab[4]  = '{1'b1, 8'h12, 1'b1, 6'h02};
    gap_tab[5]  = '{1'b0, 8'hAA, 1'b0, 6'h08};
    gap_tab[6]  = '{1'b1, 8'h13, 1'b1, 6'h08};
    gap_tab[7]  = '{1'b1, 8'h14, 1'b1, 6'h09};
    gap_tab[8]  = '{1'b0, 8'h66, 1'b0, 6'h0A};
    gap_tab[9]  = '{1'b1, 8'h15, 1'b1, 6'h0A};
    gap_tab[10] = '{1'b1, 8'h16, 1'b1, 6'h10};
    gap_tab[11] = '{1'b1, 8'h17, 1'b1, 6'h11};
    gap_tab[12] = '{1'b0, 8'h99, 1'b0, 6'h12};
    gap_tab[13] = '{1'b1, 8'h18, 1'b1, 6'h12};

    rst = 1'b1;
    s_valid = 1'b0;
    s_data = 8'h00;
    m_ready = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    #4;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_wr_en", ram_wr_en, 0);
    chk("rst_rd_en", ram_rd_en, 0);
    chk("rst_addr_in", ram_addr_in, 0);
    chk("rst_addr_out", ram_addr_out, 0);
    chk("rst_tile_done", tile_done, 0);
    next_cycle();

    // Contiguous fill, then full-rate drain with latency check
    fill_contig(8'h10);
    m_ready = 1'b1;
    #4;
    chk("drain0_s_ready", s_ready, 0);
    chk("drain0_rd_en", ram_rd_en, 1);
    chk("drain0_m_valid", m_valid, 0);
    chk("drain0_addr", ram_addr_out, exp_raddr[0]);
    next_cycle();
    drain(9, 16'hFFFF, 8'h10, 1);
    #4;
    chk("post_s_ready", s_ready, 1);
    chk("post_m_valid", m_valid, 0);
    next_cycle();

    // Fill with s_valid gaps, then drain with m_ready toggling
    for (int i = 0; i < 14; i++) begin
      s_valid = gap_tab[i].v;
      s_data  = gap_tab[i].d;
      #4;
      chk("gap_s_ready", s_ready, 1);
      chk("gap_wr_en", ram_wr_en, gap_tab[i].wr);
      chk("gap_addr", ram_addr_in, gap_tab[i].a);
      next_cycle();
    end
    s_valid = 1'b0;
    drain(9, 16'h5555, 8'h10, 0);
    #4;
    chk("post2_s_ready", s_ready, 1);
    chk("post2_m_valid", m_valid, 0);
    next_cycle();

    // Reset after 4 output bytes discards the drain
    fill_contig(8'h40);
    drain(4, 16'hFFFF, 8'h40, 0);
    rst = 1'b1;
    #4;
    next_cycle();
    rst = 1'b0;
    #4;
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_s_ready", s_ready, 1);
    chk("midrst_rd_en", ram_rd_en, 0);
    next_cycle();
    fill_contig(8'h20);
    drain(9, 16'hFFFF, 8'h20, 0);
    #4;
    chk("post3_s_ready", s_ready, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
